// File: rtl/trap_controller_if.sv
// rtl/trap_controller_if.sv - execute-stage / CSR-unit bundle for the trap controller
//
// Purpose: groups every trap_controller signal except clk/rst.
// Modports:
//   master - upstream side: drives execute-stage events, payload and CSR read values;
//            observes strobes, payload, stall, flush, redirect and trap_count.
//   slave  - trap_controller side (the mirror image of master).
// Parameter MEM_ADDR_W sets the width of mem_addr_in / csr_mem_addr.

interface trap_controller_if #(
  parameter int MEM_ADDR_W = 15
);
  // execute stage -> controller
  logic                  valid_in;
  logic                  ecall_in;
  logic                  ebreak_in;
  logic                  mret_in;
  logic                  misaligned_in;
  logic                  misaligned_store_in;
  logic [31:0]           pc_in;
  logic [31:0]           instr_in;
  logic [MEM_ADDR_W-1:0] mem_addr_in;
  logic [31:0]           store_value_in;
  logic [4:0]            rd_addr_in;
  // CSR unit read path -> controller
  logic [31:0]           mtvec_in;
  logic [31:0]           mepc_in;
  // controller -> CSR unit
  logic                  csr_ecall;
  logic                  csr_ebreak;
  logic                  csr_mret;
  logic                  csr_misaligned;
  logic                  csr_misaligned_store;
  logic [31:0]           csr_pc;
  logic [31:0]           csr_in;
  logic [MEM_ADDR_W-1:0] csr_mem_addr;
  logic [31:0]           csr_store_value;
  logic [4:0]            csr_rd_addr;
  // controller -> pipeline / fetch
  logic                  stall;
  logic                  flush;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic [31:0]           trap_count;

  modport master (
    output valid_in, ecall_in, ebreak_in, mret_in, misaligned_in, misaligned_store_in,
    output pc_in, instr_in, mem_addr_in, store_value_in, rd_addr_in, mtvec_in, mepc_in,
    input  csr_ecall, csr_ebreak, csr_mret, csr_misaligned, csr_misaligned_store,
    input  csr_pc, csr_in, csr_mem_addr, csr_store_value, csr_rd_addr,
    input  stall, flush, redirect_valid, redirect_pc, trap_count
  );

  modport slave (
    input  valid_in, ecall_in, ebreak_in, mret_in, misaligned_in, misaligned_store_in,
    input  pc_in, instr_in, mem_addr_in, store_value_in, rd_addr_in, mtvec_in, mepc_in,
    output csr_ecall, csr_ebreak, csr_mret, csr_misaligned, csr_misaligned_store,
    output csr_pc, csr_in, csr_mem_addr, csr_store_value, csr_rd_addr,
    output stall, flush, redirect_valid, redirect_pc, trap_count
  );
endinterface

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - ecall/ebreak/mret/misaligned trap sequencer between execute and CSR unit
//
// Purpose: detects a system event on a valid execute-stage instruction, captures its
// payload, strobes the CSR unit for one cycle, flushes the pipeline for FLUSH_CYCLES
// cycles and then redirects fetch to mtvec (traps) or mepc (mret). Upstream is stalled
// for the whole sequence; events arriving outside IDLE are dropped.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset; aborts any sequence in flight
//   bus  - trap_controller_if.slave: events/payload/CSR values in; csr_* strobes and
//          payload, stall (combinational), flush, redirect_valid/redirect_pc, trap_count out
// Parameters:
//   FLUSH_CYCLES - cycles flush stays high (1..15)
//   MEM_ADDR_W   - width of the captured data address
// Build option:
//   TRAP_COUNTER_EN - when defined, trap_count counts committed ecall/ebreak/misaligned
//                     traps (saturating); otherwise trap_count is tied to 0.

module trap_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_ADDR_W   = 15
) (
  input logic               clk,
  input logic               rst,
  trap_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    FLUSH    = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    KIND_EBREAK     = 2'd0,
    KIND_ECALL      = 2'd1,
    KIND_MISALIGNED = 2'd2,
    KIND_MRET       = 2'd3
  } kind_t;

  // Counter is loaded on leaving COMMIT and FLUSH ends when it has reached 0,
  // so loading FLUSH_CYCLES-1 gives exactly FLUSH_CYCLES flush cycles.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t state;
  state_t state_next;
  kind_t  evt_kind;
  kind_t  cap_kind;
  logic   evt;
  logic   stall_c;
  logic [3:0] flush_cnt;
  logic [31:0] redirect_base;

  logic                  csr_ecall_q;
  logic                  csr_ebreak_q;
  logic                  csr_mret_q;
  logic                  csr_misaligned_q;
  logic                  csr_misaligned_store_q;
  logic [31:0]           csr_pc_q;
  logic [31:0]           csr_in_q;
  logic [MEM_ADDR_W-1:0] csr_mem_addr_q;
  logic [31:0]           csr_store_value_q;
  logic [4:0]            csr_rd_addr_q;
  logic                  flush_q;
  logic                  redirect_valid_q;
  logic [31:0]           redirect_pc_q;

  assign evt = bus.valid_in &
               (bus.ecall_in | bus.ebreak_in | bus.misaligned_in | bus.mret_in);

  // Priority ebreak > ecall > misaligned > mret; only meaningful when evt is set.
  always_comb begin
    evt_kind = KIND_MRET;
    if (bus.ebreak_in) begin
      evt_kind = KIND_EBREAK;
    end else if (bus.ecall_in) begin
      evt_kind = KIND_ECALL;
    end else if (bus.misaligned_in) begin
      evt_kind = KIND_MISALIGNED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall_c    = 1'b1;
    case (state)
      IDLE: begin
        stall_c = evt;
        if (evt) begin
          state_next = COMMIT;
        end
      end
      COMMIT:   state_next = FLUSH;
      FLUSH: begin
        if (flush_cnt == 4'd0) begin
          state_next = REDIRECT;
        end
      end
      REDIRECT: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_kind <= KIND_EBREAK;
    end else if (state == IDLE && evt) begin
      cap_kind <= evt_kind;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= 4'd0;
    end else if (state == COMMIT) begin
      flush_cnt <= FLUSH_LOAD;
    end else if (state == FLUSH && flush_cnt != 4'd0) begin
      flush_cnt <= flush_cnt - 4'd1;
    end
  end

  // mtvec/mepc are only looked at while leaving the last FLUSH cycle, so any CSR
  // write made in response to the COMMIT strobe has already landed.
  assign redirect_base = (cap_kind == KIND_MRET) ? bus.mepc_in : bus.mtvec_in;

  // Registered outputs: strobes and payload are loaded on entry to COMMIT and
  // cleared the cycle after, so they read 0 in every other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      csr_ecall_q            <= 1'b0;
      csr_ebreak_q           <= 1'b0;
      csr_mret_q             <= 1'b0;
      csr_misaligned_q       <= 1'b0;
      csr_misaligned_store_q <= 1'b0;
      csr_pc_q               <= 32'd0;
      csr_in_q               <= 32'd0;
      csr_mem_addr_q         <= '0;
      csr_store_value_q      <= 32'd0;
      csr_rd_addr_q          <= 5'd0;
      flush_q                <= 1'b0;
      redirect_valid_q       <= 1'b0;
      redirect_pc_q          <= 32'd0;
    end else begin
      csr_ecall_q            <= 1'b0;
      csr_ebreak_q           <= 1'b0;
      csr_mret_q             <= 1'b0;
      csr_misaligned_q       <= 1'b0;
      csr_misaligned_store_q <= 1'b0;
      csr_pc_q               <= 32'd0;
      csr_in_q               <= 32'd0;
      csr_mem_addr_q         <= '0;
      csr_store_value_q      <= 32'd0;
      csr_rd_addr_q          <= 5'd0;
      redirect_valid_q       <= 1'b0;
      redirect_pc_q          <= 32'd0;

      if (state == IDLE && evt) begin
        case (evt_kind)
          KIND_EBREAK: csr_ebreak_q <= 1'b1;
          KIND_ECALL:  csr_ecall_q  <= 1'b1;
          KIND_MISALIGNED: begin
            csr_misaligned_q       <= 1'b1;
            csr_misaligned_store_q <= bus.misaligned_store_in;
            csr_in_q               <= bus.instr_in;
          end
          default:     csr_mret_q   <= 1'b1;
        endcase
        csr_pc_q          <= bus.pc_in;
        csr_mem_addr_q    <= bus.mem_addr_in;
        csr_store_value_q <= bus.store_value_in;
        csr_rd_addr_q     <= bus.rd_addr_in;
      end

      flush_q <= (state_next == FLUSH);

      if (state_next == REDIRECT) begin
        redirect_valid_q <= 1'b1;
        redirect_pc_q    <= {redirect_base[31:2], 2'b00};
      end
    end
  end

`ifdef TRAP_COUNTER_EN
  logic [31:0] trap_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_count_q <= 32'd0;
    end else if (state == COMMIT && cap_kind != KIND_MRET && trap_count_q != 32'hFFFF_FFFF) begin
      trap_count_q <= trap_count_q + 32'd1;
    end
  end

  assign bus.trap_count = trap_count_q;
`else
  assign bus.trap_count = 32'd0;
`endif

  assign bus.stall                = stall_c;
  assign bus.csr_ecall            = csr_ecall_q;
  assign bus.csr_ebreak           = csr_ebreak_q;
  assign bus.csr_mret             = csr_mret_q;
  assign bus.csr_misaligned       = csr_misaligned_q;
  assign bus.csr_misaligned_store = csr_misaligned_store_q;
  assign bus.csr_pc               = csr_pc_q;
  assign bus.csr_in               = csr_in_q;
  assign bus.csr_mem_addr         = csr_mem_addr_q;
  assign bus.csr_store_value      = csr_store_value_q;
  assign bus.csr_rd_addr          = csr_rd_addr_q;
  assign bus.flush                = flush_q;
  assign bus.redirect_valid       = redirect_valid_q;
  assign bus.redirect_pc          = redirect_pc_q;

endmodule
